// File: rtl/rd_sdram.sv
// rd_sdram: PAL frame reader. Fetches 720-pixel lines from SDRAM as bursts of
//   256/256/208 words (one line per four 256-word rows) and streams them to the output FIFO.
// Latency: read data is registered, so a beat reaches the FIFO 1 cycle after sdram_rd_valid.
//   rd_req rises 1 cycle after IDLE sees room, and falls 1 cycle after rd_ack.
// Backpressure: a burst is requested only while the FIFO fill is below FIFO_LOW. After that
//   the FIFO is never checked, because FIFO_LOW + 256 <= 512 always leaves room.
//
// Configuration macro: RD_FIELD_BASE_EN. When defined, field is taken on vs_neg and selects
//   the row base 14'h2000 (field=1) or 14'h0000. When undefined, the base is always 0.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   vs_neg, field                frame-start pulse (synchronous restart), field indicator
//   wrusedw_fifo                 output FIFO fill level (512 deep)
//   wr_en_fifo, fifo_data        output FIFO write strobe / data
//   rd_req, rd_ack               burst request / one-cycle controller accept
//   rd_burst_length              words in the requested burst (256 or 208)
//   rd_burst_address             SDRAM word address {row_addr, 8'b0}
//   sdram_rd_valid, sdram_data   controller read beats
//   rd_frame_done                one-cycle pulse when the frame's last burst completes
module rd_sdram #(
  parameter int ACTIVE_LINES = 576,
  parameter int FIFO_LOW     = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vs_neg,
  input  logic        field,
  input  logic [8:0]  wrusedw_fifo,
  output logic        wr_en_fifo,
  output logic [15:0] fifo_data,
  output logic        rd_req,
  input  logic        rd_ack,
  output logic [8:0]  rd_burst_length,
  output logic [21:0] rd_burst_address,
  input  logic        sdram_rd_valid,
  input  logic [15:0] sdram_data,
  output logic        rd_frame_done
);

  localparam logic [9:0] FIFO_LOW_W = 10'(FIFO_LOW);
  localparam logic [9:0] LAST_LINE  = 10'(ACTIVE_LINES - 1);

`ifdef RD_FIELD_BASE_EN
  localparam logic [13:0] FIELD_ROW_BASE = 14'h2000;
`else
  localparam logic [13:0] FIELD_ROW_BASE = 14'h0000;
`endif

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_REQ     = 3'd1,
    BURST      = 3'd2,
    STATE_NOP  = 3'd3,
    FRAME_DONE = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_next_state;

  logic         r_rd_req;
  logic [8:0]   r_rd_burst_length;
  logic [21:0]  r_rd_burst_address;
  logic         r_wr_en;
  logic [15:0]  r_fifo_data;
  logic         r_frame_done;

  logic [13:0]  r_row_addr;
  logic [1:0]   r_burst_in_line;
  logic [9:0]   r_line_cnt;
  logic [8:0]   r_beat_cnt;
  // Set by vs_neg, cleared by the next accepted request: blocks stale beats
  // belonging to a burst that was aborted by a frame restart.
  logic         r_suppress;

  logic         w_fifo_low;
  logic [8:0]   w_len;
  logic [13:0]  w_base;
  logic         w_start;
  logic         w_ack;
  logic         w_beat;
  logic         w_wr;
  logic         w_advance;
  logic         w_frame_done;

  assign w_fifo_low = {1'b0, wrusedw_fifo} < FIFO_LOW_W;
  assign w_len      = (r_burst_in_line == 2'd2) ? 9'd208 : 9'd256;
  // With the field feature off, FIELD_ROW_BASE is zero and field has no effect.
  assign w_base     = field ? FIELD_ROW_BASE : 14'h0000;
  assign w_wr       = w_beat & ~r_suppress;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and datapath strobes. vs_neg overrides every state, and it also
  // masks any rd_ack or beat seen in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_ack        = 1'b0;
    w_beat       = 1'b0;
    w_advance    = 1'b0;
    w_frame_done = 1'b0;
    if (vs_neg) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fifo_low) begin
            w_start      = 1'b1;
            w_next_state = RD_REQ;
          end
        end
        RD_REQ: begin
          if (rd_ack) begin
            w_ack        = 1'b1;
            w_next_state = BURST;
          end
        end
        BURST: begin
          if (sdram_rd_valid) begin
            w_beat = 1'b1;
            if (r_beat_cnt == 9'd1) begin
              w_next_state = STATE_NOP;
            end
          end
        end
        STATE_NOP: begin
          w_advance = 1'b1;
          if ((r_burst_in_line == 2'd2) && (r_line_cnt == LAST_LINE)) begin
            w_frame_done = 1'b1;
            w_next_state = FRAME_DONE;
          end else begin
            w_next_state = IDLE;
          end
        end
        FRAME_DONE: begin
          w_next_state = FRAME_DONE;
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_req           <= 1'b0;
      r_rd_burst_length  <= 9'd0;
      r_rd_burst_address <= 22'd0;
      r_wr_en            <= 1'b0;
      r_fifo_data        <= 16'd0;
      r_frame_done       <= 1'b0;
      r_row_addr         <= 14'd0;
      r_burst_in_line    <= 2'd0;
      r_line_cnt         <= 10'd0;
      r_beat_cnt         <= 9'd0;
      r_suppress         <= 1'b0;
    end else begin
      r_wr_en      <= w_wr;
      r_frame_done <= w_frame_done;
      if (w_wr) begin
        r_fifo_data <= sdram_data;
      end

      if (vs_neg) begin
        r_rd_req        <= 1'b0;
        r_row_addr      <= w_base;
        r_burst_in_line <= 2'd0;
        r_line_cnt      <= 10'd0;
        r_beat_cnt      <= 9'd0;
        r_suppress      <= 1'b1;
      end else begin
        if (w_start) begin
          r_rd_req           <= 1'b1;
          r_rd_burst_length  <= w_len;
          r_rd_burst_address <= {r_row_addr, 8'h00};
          r_beat_cnt         <= w_len;
        end

        if (w_ack) begin
          r_rd_req   <= 1'b0;
          r_suppress <= 1'b0;
        end

        if (w_beat) begin
          r_beat_cnt <= r_beat_cnt - 9'd1;
        end

        // Rows 0..2 of a line are consecutive. The fourth row slot is unused,
        // so the last burst of a line skips ahead by two rows.
        if (w_advance) begin
          if (r_burst_in_line == 2'd2) begin
            r_row_addr      <= r_row_addr + 14'd2;
            r_burst_in_line <= 2'd0;
            r_line_cnt      <= r_line_cnt + 10'd1;
          end else begin
            r_row_addr      <= r_row_addr + 14'd1;
            r_burst_in_line <= r_burst_in_line + 2'd1;
          end
        end
      end
    end
  end

  assign rd_req           = r_rd_req;
  assign rd_burst_length  = r_rd_burst_length;
  assign rd_burst_address = r_rd_burst_address;
  assign wr_en_fifo       = r_wr_en;
  assign fifo_data        = r_fifo_data;
  assign rd_frame_done    = r_frame_done;

endmodule
